// File: rtl/seq_detector_prog.sv
// Programmable serial bit-sequence detector: run-time loaded pattern of 1..PAT_W bits,
// overlapping or non-overlapping detection. Define SEQDET_COUNT_EN to build the saturating match counter.
module seq_detector_prog #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             overlap_i,
  input  logic             valid_i,
  input  logic             in_i,
  input  logic             clear_i,
  output logic             armed_o,
  output logic             detected_o,
  output logic [CNT_W-1:0] match_cnt_o
);

  typedef enum logic [1:0] {IDLE, FILL, HUNT} state_t;

  state_t           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] hist_q;
  logic [PAT_W-1:0] hist_nxt;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] fill_q;
  logic [LEN_W-1:0] fill_nxt;
  logic             ovl_q;
  logic             detected_q;
  logic             len_ok;
  logic             accept;
  logic             hit;

  // Load and clear take priority, so a bit in the same cycle is never accepted.
  always_comb begin
    len_ok   = (len_i != '0) && (len_i <= LEN_W'(PAT_W));
    accept   = valid_i && (state_q != IDLE) && !load_i && !clear_i;
    hist_nxt = {hist_q[PAT_W-2:0], in_i};
    fill_nxt = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;
    mask     = ~({PAT_W{1'b1}} << len_q);
    hit      = accept && (fill_nxt == len_q) && ((hist_nxt & mask) == (pat_q & mask));
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      len_q      <= '0;
      ovl_q      <= 1'b0;
      hist_q     <= '0;
      fill_q     <= '0;
      detected_q <= 1'b0;
    end else begin
      detected_q <= 1'b0;
      if (load_i) begin
        pat_q   <= pattern_i;
        len_q   <= len_i;
        ovl_q   <= overlap_i;
        hist_q  <= '0;
        fill_q  <= '0;
        state_q <= len_ok ? FILL : IDLE;
      end else if (clear_i) begin
        hist_q <= '0;
        fill_q <= '0;
        if (state_q != IDLE) state_q <= FILL;
      end else if (accept) begin
        detected_q <= hit;
        // Non-overlapping: a match consumes its bits, so hunting restarts from empty.
        if (hit && !ovl_q) begin
          hist_q  <= '0;
          fill_q  <= '0;
          state_q <= FILL;
        end else begin
          hist_q  <= hist_nxt;
          fill_q  <= fill_nxt;
          state_q <= (fill_nxt == len_q) ? HUNT : FILL;
        end
      end
    end
  end

  assign armed_o    = (state_q != IDLE);
  assign detected_o = detected_q;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Survives pattern reloads; only clear_i and reset zero it.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt_o = cnt_q;
`else
  assign match_cnt_o = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: directed vector table, a reset-mid-stream sequence,
// and randomized traffic against a queue-based reference model.
module tb_seq_detector_prog;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef SEQDET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic             load_i = 1'b0;
  logic [PAT_W-1:0] pattern_i = '0;
  logic [LEN_W-1:0] len_i = '0;
  logic             overlap_i = 1'b0;
  logic             valid_i = 1'b0;
  logic             in_i = 1'b0;
  logic             clear_i = 1'b0;
  logic             armed_o;
  logic             detected_o;
  logic [CNT_W-1:0] match_cnt_o;

  seq_detector_prog #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_i(reset_i), .load_i(load_i), .pattern_i(pattern_i),
    .len_i(len_i), .overlap_i(overlap_i), .valid_i(valid_i), .in_i(in_i),
    .clear_i(clear_i), .armed_o(armed_o), .detected_o(detected_o),
    .match_cnt_o(match_cnt_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int cexp(input int c);
    return CNT_ON ? c : 0;
  endfunction

  // Reference model: the bits received since the last restart, newest at the back.
  bit         mq[$];
  bit         m_arm, m_ovl, m_det;
  logic [7:0] m_pat;
  int         m_len, m_cnt;

  function automatic void model_reset();
    mq.delete();
    m_arm = 0; m_ovl = 0; m_det = 0; m_pat = '0; m_len = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(input bit ld, input logic [7:0] p, input int l,
                                     input bit ov, input bit v, input bit b, input bit c);
    bit match;
    m_det = 0;
    if (ld) begin
      m_arm = (l >= 1) && (l <= PAT_W);
      m_pat = p; m_len = l; m_ovl = ov;
      mq.delete();
      if (c) m_cnt = 0;
    end else if (c) begin
      mq.delete();
      m_cnt = 0;
    end else if (v && m_arm) begin
      mq.push_back(b);
      if (mq.size() > PAT_W) void'(mq.pop_front());
      match = (mq.size() >= m_len);
      for (int i = 0; i < m_len && match; i++)
        if (mq[mq.size() - m_len + i] != m_pat[m_len - 1 - i]) match = 0;
      if (match) begin
        m_det = 1;
        if (m_cnt < CMAX) m_cnt++;
        if (!m_ovl) mq.delete();
      end
    end
  endfunction

  task automatic step(input bit ld, input logic [7:0] p, input int l,
                      input bit ov, input bit v, input bit b, input bit c);
    load_i = ld; pattern_i = p; len_i = LEN_W'(l); overlap_i = ov;
    valid_i = v; in_i = b; clear_i = c;
    model_step(ld, p, l, ov, v, b, c);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit ld; logic [7:0] pat; int len; bit ov, v, b, clr;
    bit e_det, e_arm; int e_cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit ld, input logic [7:0] pat, input int len, input bit ov,
                              input bit v, input bit b, input bit clr,
                              input bit ed, input bit ea, input int ec);
    vec_t r;
    r.ld = ld; r.pat = pat; r.len = len; r.ov = ov; r.v = v; r.b = b; r.clr = clr;
    r.e_det = ed; r.e_arm = ea; r.e_cnt = ec;
    tbl.push_back(r);
  endfunction
  function automatic void addb(input bit b, input bit ed, input bit ea, input int ec);
    add(0, 8'h00, 0, 0, 1, b, 0, ed, ea, ec);
  endfunction
  function automatic void addg(input bit b, input bit ea, input int ec);
    add(0, 8'h00, 0, 0, 0, b, 0, 0, ea, ec);
  endfunction
  function automatic void addc(input bit v, input bit ea);
    add(0, 8'h00, 0, 0, v, 1, 1, 0, ea, 0);
  endfunction

  function automatic void build_table();
    addb(1, 0, 0, 0); addb(0, 0, 0, 0); addb(1, 0, 0, 0);          // no pattern yet
    add(1, 8'h0B, 4, 1, 1, 1, 0, 0, 1, 0);                          // load drops this bit
    addb(0, 0, 1, 0); addb(1, 0, 1, 0); addb(1, 0, 1, 0);
    addc(0, 1);
    addb(1, 0, 1, 0); addb(0, 0, 1, 0); addb(1, 0, 1, 0); addb(1, 1, 1, 1);
    addb(0, 0, 1, 1); addb(1, 0, 1, 1); addb(1, 1, 1, 2);          // overlap
    add(1, 8'h0B, 4, 0, 0, 0, 0, 0, 1, 2);
    addb(1, 0, 1, 2); addb(0, 0, 1, 2); addb(1, 0, 1, 2); addb(1, 1, 1, 3);
    addb(0, 0, 1, 3); addb(1, 0, 1, 3); addb(1, 0, 1, 3);          // non-overlap
    addc(0, 1);
    add(1, 8'h03, 2, 0, 0, 0, 0, 0, 1, 0);
    addb(1, 0, 1, 0); addb(1, 1, 1, 1); addb(1, 0, 1, 1); addb(1, 1, 1, 2);
    add(1, 8'h03, 2, 1, 0, 0, 1, 0, 1, 0);                          // load + clear
    addb(1, 0, 1, 0); addb(1, 1, 1, 1); addb(1, 1, 1, 2); addb(1, 1, 1, 3); addb(1, 1, 1, 3);
    addc(0, 1);
    add(1, 8'h05, 3, 1, 0, 0, 0, 0, 1, 0);
    addb(1, 0, 1, 0); addg(1, 1, 0); addb(0, 0, 1, 0); addg(0, 1, 0); addb(1, 1, 1, 1);
    addc(0, 1);
    addb(1, 0, 1, 0); addb(0, 0, 1, 0); addc(1, 1); addb(1, 0, 1, 0);
    addb(0, 0, 1, 0); addb(1, 1, 1, 1);
    add(1, 8'h01, 1, 0, 0, 0, 1, 0, 1, 0);                          // len 1, saturation
    addb(1, 1, 1, 1); addb(1, 1, 1, 2); addb(0, 0, 1, 2); addb(1, 1, 1, 3);
    addb(1, 1, 1, 3); addb(1, 1, 1, 3);
    addc(0, 1);
    add(1, 8'hA5, 8, 0, 0, 0, 0, 0, 1, 0);                          // full length
    addb(1, 0, 1, 0); addb(0, 0, 1, 0); addb(1, 0, 1, 0); addb(0, 0, 1, 0);
    addb(0, 0, 1, 0); addb(1, 0, 1, 0); addb(0, 0, 1, 0); addb(1, 1, 1, 1);
    add(1, 8'h0B, 0, 1, 0, 0, 0, 0, 0, 1);                          // illegal lengths
    addb(1, 0, 0, 1);
    add(1, 8'h0B, PAT_W + 1, 1, 1, 1, 0, 0, 0, 1);
    addb(1, 0, 0, 1);
    addc(0, 0);
    addb(1, 0, 0, 0);
  endfunction

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    #2 reset_i = 1'b0;
    #1;
    check("reset armed", int'(armed_o), 0);
    check("reset det", int'(detected_o), 0);
    check("reset cnt", int'(match_cnt_o), 0);
    @(posedge clk); @(posedge clk); #1;
    reset_i = 1'b1;

    build_table();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ov, tbl[i].v, tbl[i].b, tbl[i].clr);
      check($sformatf("vec%0d det", i), int'(detected_o), int'(tbl[i].e_det));
      check($sformatf("vec%0d armed", i), int'(armed_o), int'(tbl[i].e_arm));
      check($sformatf("vec%0d cnt", i), int'(match_cnt_o), cexp(tbl[i].e_cnt));
    end

    // Reset between edges after 3 of 4 pattern bits.
    step(1, 8'h01, 1, 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1, 1, 0);
    check("pre-rst det", int'(detected_o), 1);
    check("pre-rst cnt", int'(match_cnt_o), cexp(1));
    step(1, 8'h0B, 4, 1, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1, 1, 0);
    step(0, 8'h00, 0, 0, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1, 1, 0);
    #2 reset_i = 1'b0;
    model_reset();
    #1;
    check("async rst armed", int'(armed_o), 0);
    check("async rst det", int'(detected_o), 0);
    check("async rst cnt", int'(match_cnt_o), 0);
    #3 reset_i = 1'b1;
    step(0, 8'h00, 0, 0, 1, 1, 0);
    check("post-rst idle armed", int'(armed_o), 0);
    check("post-rst idle det", int'(detected_o), 0);
    step(1, 8'h0B, 4, 1, 0, 0, 0);
    check("reload armed", int'(armed_o), 1);
    step(0, 8'h00, 0, 0, 1, 1, 0);
    check("last bit alone det", int'(detected_o), 0);
    check("last bit alone cnt", int'(match_cnt_o), 0);

    for (int k = 0; k < 1500; k++) begin
      bit ld, ov, v, b, c;
      logic [7:0] p;
      int l;
      ld = ($urandom_range(0, 19) == 0);
      c  = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom_range(0, 1));
      ov = 1'($urandom_range(0, 1));
      p  = 8'($urandom);
      l  = $urandom_range(0, 1) ? $urandom_range(1, 3) : $urandom_range(0, PAT_W + 1);
      step(ld, p, l, ov, v, b, c);
      check($sformatf("rnd%0d det", k), int'(detected_o), int'(m_det));
      check($sformatf("rnd%0d armed", k), int'(armed_o), int'(m_arm));
      check($sformatf("rnd%0d cnt", k), int'(match_cnt_o), cexp(m_cnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Programmable serial bit-sequence detector: the next-generation replacement for the fixed-pattern detector FSM. It matches a run-time-loaded pattern of 1..PAT_W bits against a qualified serial bit stream, with selectable overlapping or non-overlapping detection and an optional saturating match counter. It sits on the serial input path and drives a one-cycle detect pulse to downstream control logic.

## Interface
- PAT_W, 8: maximum pattern length in bits (>= 2)
- CNT_W, 8: match counter width (>= 1)
- LEN_W, derived $clog2(PAT_W+1): width of len_i (localparam)

- clk  in  1  rising-edge clock
- reset_i  in  1  asynchronous, active-low reset
- load_i  in  1  capture pattern_i, len_i and overlap_i; restart detection
- pattern_i  in  PAT_W  pattern; bit len-1 is the first bit received, bit 0 is the last bit received
- len_i  in  LEN_W  active pattern length; legal values 1..PAT_W
- overlap_i  in  1  1 = overlapping detection, 0 = non-overlapping
- valid_i  in  1  in_i is accepted on a rising edge only when valid_i = 1
- in_i  in  1  serial data bit
- clear_i  in  1  synchronous clear of the counter and the history
- armed_o  out  1  a legal pattern is loaded (state != IDLE)
- detected_o  out  1  registered one-cycle match pulse
- match_cnt_o  out  CNT_W  saturating count of matches

## Operation
- Registers: pat_q, len_q, ovl_q; hist (PAT_W-bit shift register, new bit enters at bit 0); fill (count of bits held in the history, saturates at len_q); cnt.
- FSM states:
  - IDLE: no legal pattern. Input bits are ignored.
  - FILL: fill < len_q.
  - HUNT: fill == len_q. Compare on every accepted bit.
- Transitions:
  - Reset -> IDLE.
  - load_i with len_i in 1..PAT_W: -> FILL with hist = 0 and fill = 0.
  - load_i with len_i = 0 or len_i > PAT_W: -> IDLE.
  - FILL -> HUNT when an accepted bit makes fill == len_q.
  - HUNT after a match with ovl_q = 0 -> FILL with hist and fill cleared.
  - HUNT after a match with ovl_q = 1 -> stays in HUNT, history retained.
- Match condition: accepted bit with the updated hist[len_q-1:0] == pat_q[len_q-1:0] and the updated fill == len_q.
- len_q = 1: every accepted bit equal to pat_q[0] matches, in both modes.
- Priority within one cycle: load_i > clear_i > accepted bit.
  - load_i and valid_i together: the bit is discarded.
  - load_i and clear_i together: the pattern is loaded and the counter is cleared.
  - clear_i: hist and fill go to 0, the state goes to FILL (or stays IDLE), and cnt goes to 0. A bit arriving in the same cycle is discarded and detected_o = 0 next cycle.
- valid_i = 0: hist, fill and state hold. detected_o = 0 next cycle.
- Counter: increments by 1 per match and saturates at 2^CNT_W-1. Reloading a pattern does not clear it; only clear_i and reset do.

## Timing
- Reset values:
  - armed_o = 0, detected_o = 0, match_cnt_o = 0
  - hist = 0, fill = 0, pat_q = 0, len_q = 0, ovl_q = 0, state IDLE
- Latency:
  - detected_o is high for exactly one cycle, in the cycle after the edge that samples the completing bit.
  - match_cnt_o updates on the same edge that raises detected_o.
  - armed_o is valid the cycle after load_i.
- Back-to-back matches in overlap mode (e.g. pattern 11 with valid_i held high): detected_o stays high on consecutive cycles, one cycle per match.
- Reset asserted mid-stream: all outputs go to 0 immediately (asynchronously). After release, the block is in IDLE and needs a new load_i.
- All other inputs are sampled on rising clk edges only.

## Configuration
- SEQDET_COUNT_EN defined: cnt is implemented as described and drives match_cnt_o.
- SEQDET_COUNT_EN undefined: no counter registers are built, match_cnt_o is tied to 0, and clear_i still clears the history.

## Test plan
- Reset and arming: reset, then stream bits without load_i -> armed_o = 0, detected_o never asserts. Then load pattern 1011 with len 4 -> armed_o = 1 one cycle later.
- Overlap mode: pattern 1011, len 4, overlap_i = 1; stream 1,0,1,1,0,1,1 with valid_i held high -> detected_o pulses after bit 4 and after bit 7, match_cnt_o = 2.
- Non-overlap mode: same stream with overlap_i = 0 -> a single pulse after bit 4, match_cnt_o = 1. Pattern 11, len 2, stream 1,1,1,1 -> 2 pulses (overlap mode gives 3, on consecutive cycles).
- Valid gaps and priority:
  - Pattern 101; stream 1, gap, 0, gap, 1 -> one pulse after the last bit.
  - load_i together with valid_i -> that bit is dropped.
  - clear_i after bits 1,0 followed by 1 -> no pulse.
- Saturation with CNT_W = 2 and SEQDET_COUNT_EN defined: 5 matches of pattern 1, len 1 -> match_cnt_o stops at 3. clear_i -> 0. Build without the macro -> match_cnt_o is always 0.
- Illegal length and reset mid-stream: load with len 0 or len PAT_W+1 -> armed_o = 0. Assert reset_i between clock edges after 3 of 4 pattern bits -> outputs go to 0 at once; after reload, the remaining bit alone does not produce a match.
